i2c_cmd_sequencer: RTL and testbench

Command-level front end for the I2C master interface. It accepts one I2C transaction descriptor at a time from the SiTCP register side over a valid/ready handshake and drives the master's flag/address/data inputs with a correctly shaped one-cycle start pulse. It supervises the master's `busy` output, enforces bus-free time between transactions, and buffers returned read words in a first-word-fall-through result FIFO with a per-transaction `last` marker.

---
 rtl/i2c_cmd_sequencer_if.sv | 52 +++++
 rtl/i2c_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// i2c_cmd_sequencer_if
// Bundles the three streams around the I2C command sequencer:
//   cmd_*   : transaction descriptor handshake from the register side
//   m_*     : field/flag outputs to the I2C master, plus its busy/read-data
//   res_*   : first-word-fall-through result stream of read words
// Modports:
//   slave  : the sequencer itself (accepts commands, drives the master fields)
//   master : the surrounding logic (issues commands, models the I2C master,
//            consumes results)
// ----------------------------------------------------------------------------
interface i2c_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [47:0] cmd_data;

   logic [6:0]  m_adr;
   logic [31:0] m_wr_data;
   logic [2:0]  m_wr_bytes;
   logic [2:0]  m_rd_bytes;
   logic [3:0]  m_rd_channels;
   logic        m_wr_flg;
   logic        m_rd_flg;
   logic [31:0] m_rd_data;
   logic        m_rd_data_en;
   logic        m_busy;

   logic        res_valid;
   logic [31:0] res_data;
   logic        res_last;
   logic        res_ready;

   modport slave (
      input  cmd_valid, cmd_data,
      input  m_rd_data, m_rd_data_en, m_busy,
      input  res_ready,
      output cmd_ready,
      output m_adr, m_wr_data, m_wr_bytes, m_rd_bytes, m_rd_channels,
      output m_wr_flg, m_rd_flg,
      output res_valid, res_data, res_last
   );

   modport master (
      output cmd_valid, cmd_data,
      output m_rd_data, m_rd_data_en, m_busy,
      output res_ready,
      input  cmd_ready,
      input  m_adr, m_wr_data, m_wr_bytes, m_rd_bytes, m_rd_channels,
      input  m_wr_flg, m_rd_flg,
      input  res_valid, res_data, res_last
   );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_cmd_sequencer
// Accepts one I2C transaction descriptor at a time, drives the master's
// address/data/length fields with a single-cycle start flag, supervises the
// master's busy output (start and timeout checks), enforces a bus-free gap
// between transactions and buffers returned read words in a FWFT FIFO whose
// entries carry a per-transaction "last" marker.
// Ports:
//   clk, reset    : 40 MHz clock, asynchronous active-high reset
//   bus (slave)   : command handshake, master fields/flags, result stream
//   clear_err     : clears all sticky error flags (a same-cycle set wins)
//   cmd_err       : descriptor rejected (bad nbytes, or read with 0 channels)
//   start_err     : master did not raise busy within ARM_CYCLES of the flag
//   timeout_err   : busy stayed high for TIMEOUT_CYCLES
//   ovf_err       : read word dropped because the result FIFO was full
//   idle          : sequencer idle and result FIFO empty
// ----------------------------------------------------------------------------
module i2c_cmd_sequencer #(
   parameter int unsigned GAP_CYCLES     = 200,
   parameter int unsigned ARM_CYCLES     = 8,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
   parameter int unsigned RES_DEPTH      = 8
) (
   input  logic                clk,
   input  logic                reset,
   i2c_cmd_sequencer_if.slave  bus,
   input  logic                clear_err,
   output logic                cmd_err,
   output logic                start_err,
   output logic                timeout_err,
   output logic                ovf_err,
   output logic                idle
);

   localparam int unsigned PTR_W    = $clog2(RES_DEPTH);
   localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);
   localparam logic [23:0] ARM_LAST = 24'(ARM_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_RUN, S_GAP} state_t;

   typedef struct packed {
      logic        rw;
      logic [6:0]  adr;
      logic [2:0]  nbytes;
      logic [3:0]  channels;
      logic        rsvd;
      logic [31:0] wr_data;
   } cmd_t;

   cmd_t cmd;
   assign cmd = bus.cmd_data;

   state_t      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [6:0]  m_adr_q, m_adr_d;
   logic [31:0] m_wr_data_q, m_wr_data_d;
   logic [2:0]  m_wr_bytes_q, m_wr_bytes_d;
   logic [2:0]  m_rd_bytes_q, m_rd_bytes_d;
   logic [3:0]  m_rd_channels_q, m_rd_channels_d;
   logic        m_wr_flg_q, m_wr_flg_d;
   logic        m_rd_flg_q, m_rd_flg_d;
   logic [4:0]  rd_cnt_q, rd_cnt_d;
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic        cmd_err_q, cmd_err_d;
   logic        start_err_q, start_err_d;
   logic        timeout_err_q, timeout_err_d;
   logic        ovf_err_q, ovf_err_d;

   logic [31:0] res_data_mem [RES_DEPTH];
   logic        res_last_mem [RES_DEPTH];

   logic           cmd_bad;
   logic           fifo_empty, fifo_full;
   logic           pop, push_ok, push_last;
   logic [5:0]     word_num;
   logic [PTR_W-1:0] wr_idx, rd_idx;

   assign cmd_bad = (cmd.nbytes == 3'd0) || (cmd.nbytes > 3'd4) ||
                    (cmd.rw && (cmd.channels == 4'd0));

   assign wr_idx     = wr_ptr_q[PTR_W-1:0];
   assign rd_idx     = rd_ptr_q[PTR_W-1:0];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
   assign pop        = bus.res_ready && !fifo_empty;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push_ok    = bus.m_rd_data_en && (!fifo_full || pop);
   // Six bits so a saturated count never wraps onto channels==0.
   assign word_num   = {1'b0, rd_cnt_q} + 6'd1;
   assign push_last  = (word_num == {2'b00, m_rd_channels_q});

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      m_adr_d         = m_adr_q;
      m_wr_data_d     = m_wr_data_q;
      m_wr_bytes_d    = m_wr_bytes_q;
      m_rd_bytes_d    = m_rd_bytes_q;
      m_rd_channels_d = m_rd_channels_q;
      m_wr_flg_d      = 1'b0;
      m_rd_flg_d      = 1'b0;
      rd_cnt_d        = rd_cnt_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      // Sticky flags: clear first, any set below overrides the clear.
      cmd_err_d       = cmd_err_q     & ~clear_err;
      start_err_d     = start_err_q   & ~clear_err;
      timeout_err_d   = timeout_err_q & ~clear_err;
      ovf_err_d       = ovf_err_q     & ~clear_err;

      // Result FIFO runs independently of the command state.
      if (bus.m_rd_data_en) begin
         if (rd_cnt_q != 5'h1f) rd_cnt_d = rd_cnt_q + 5'd1;
         if (!push_ok) ovf_err_d = 1'b1;
      end
      if (push_ok) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      if (pop)     rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (cmd_bad) begin
                  cmd_err_d = 1'b1;
               end else begin
                  m_adr_d     = cmd.adr;
                  m_wr_data_d = cmd.wr_data;
                  if (cmd.rw) begin
                     m_wr_bytes_d    = 3'd0;
                     m_rd_bytes_d    = cmd.nbytes;
                     m_rd_channels_d = cmd.channels;
                  end else begin
                     m_wr_bytes_d    = cmd.nbytes;
                     m_rd_bytes_d    = 3'd0;
                     m_rd_channels_d = 4'd0;
                  end
                  // Flags are raised here so they are registered in ISSUE.
                  m_rd_flg_d = cmd.rw;
                  m_wr_flg_d = !cmd.rw;
                  rd_cnt_d   = 5'd0;
                  state_d    = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = 24'd0;
            state_d = S_ARM;
         end
         S_ARM: begin
            if (bus.m_busy) begin
               cnt_d   = 24'd0;
               state_d = S_RUN;
            end else if (cnt_q == ARM_LAST) begin
               start_err_d = 1'b1;
               cnt_d       = 24'd0;
               state_d     = S_GAP;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         S_RUN: begin
            if (!bus.m_busy) begin
               cnt_d   = 24'd0;
               state_d = S_GAP;
            end else if (cnt_q != TIMEOUT_CYCLES) begin
               cnt_d = cnt_q + 24'd1;
               // The master cannot be aborted, so only flag it and keep waiting.
               if (cnt_q + 24'd1 == TIMEOUT_CYCLES) timeout_err_d = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 24'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         default: begin
            cnt_d   = 24'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         cnt_q           <= 24'd0;
         m_adr_q         <= 7'd0;
         m_wr_data_q     <= 32'd0;
         m_wr_bytes_q    <= 3'd0;
         m_rd_bytes_q    <= 3'd0;
         m_rd_channels_q <= 4'd0;
         m_wr_flg_q      <= 1'b0;
         m_rd_flg_q      <= 1'b0;
         rd_cnt_q        <= 5'd0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         cmd_err_q       <= 1'b0;
         start_err_q     <= 1'b0;
         timeout_err_q   <= 1'b0;
         ovf_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         m_adr_q         <= m_adr_d;
         m_wr_data_q     <= m_wr_data_d;
         m_wr_bytes_q    <= m_wr_bytes_d;
         m_rd_bytes_q    <= m_rd_bytes_d;
         m_rd_channels_q <= m_rd_channels_d;
         m_wr_flg_q      <= m_wr_flg_d;
         m_rd_flg_q      <= m_rd_flg_d;
         rd_cnt_q        <= rd_cnt_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         cmd_err_q       <= cmd_err_d;
         start_err_q     <= start_err_d;
         timeout_err_q   <= timeout_err_d;
         ovf_err_q       <= ovf_err_d;
      end
   end

   // NOTE: the storage array is not reset; the pointers define what is valid
   // and the read port is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         res_data_mem[wr_idx] <= bus.m_rd_data;
         res_last_mem[wr_idx] <= push_last;
      end
   end

   assign bus.cmd_ready     = (state_q == S_IDLE);
   assign bus.m_adr         = m_adr_q;
   assign bus.m_wr_data     = m_wr_data_q;
   assign bus.m_wr_bytes    = m_wr_bytes_q;
   assign bus.m_rd_bytes    = m_rd_bytes_q;
   assign bus.m_rd_channels = m_rd_channels_q;
   assign bus.m_wr_flg      = m_wr_flg_q;
   assign bus.m_rd_flg      = m_rd_flg_q;
   assign bus.res_valid     = !fifo_empty;
   assign bus.res_data      = fifo_empty ? 32'd0 : res_data_mem[rd_idx];
   assign bus.res_last      = fifo_empty ? 1'b0  : res_last_mem[rd_idx];

   assign cmd_err     = cmd_err_q;
   assign start_err   = start_err_q;
   assign timeout_err = timeout_err_q;
   assign ovf_err     = ovf_err_q;
   assign idle        = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
// Directed plus randomized stimulus for i2c_cmd_sequencer. The I2C master is
// modelled by the bench (busy, read strobes). Expected values come from the
// descriptor rules and a queue model of the result stream.
// ----------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;

   localparam int          GAP   = 200;
   localparam int          ARM   = 8;
   localparam logic [23:0] TMO   = 24'd3000;
   localparam int          DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   logic clear_err;
   logic cmd_err, start_err, timeout_err, ovf_err, idle;

   i2c_cmd_sequencer_if bus ();

   i2c_cmd_sequencer #(
      .GAP_CYCLES    (GAP),
      .ARM_CYCLES    (ARM),
      .TIMEOUT_CYCLES(TMO),
      .RES_DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .clear_err  (clear_err),
      .cmd_err    (cmd_err),
      .start_err  (start_err),
      .timeout_err(timeout_err),
      .ovf_err    (ovf_err),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } res_t;

   res_t        q[$];
   int          rd_count;
   int          cur_ch;
   logic        exp_ovf;
   logic [6:0]  e_adr;
   logic [31:0] e_wd;
   logic [2:0]  e_wb, e_rb;
   logic [3:0]  e_ch;
   logic [31:0] wdata [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score the result stream against the queue model, then advance.
   task automatic step();
      bit pop, push, drop;
      check("res_valid", bus.res_valid, q.size() != 0);
      pop  = bus.res_ready && (q.size() != 0);
      push = 1'b0;
      drop = 1'b0;
      if (pop) begin
         check("res_data", bus.res_data, q[0].data);
         check("res_last", bus.res_last, q[0].last);
      end
      if (bus.m_rd_data_en) begin
         rd_count++;
         if (q.size() < DEPTH || pop) push = 1'b1;
         else drop = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{bus.m_rd_data, rd_count == cur_ch});
      exp_ovf = drop || (exp_ovf && !clear_err);
      @(posedge clk);
      #1;
      check("ovf_err", ovf_err, exp_ovf);
   endtask

   task automatic check_reset_values();
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_m_adr", bus.m_adr, 0);
      check("rst_m_wr_data", bus.m_wr_data, 0);
      check("rst_m_wr_bytes", bus.m_wr_bytes, 0);
      check("rst_m_rd_bytes", bus.m_rd_bytes, 0);
      check("rst_m_rd_channels", bus.m_rd_channels, 0);
      check("rst_m_wr_flg", bus.m_wr_flg, 0);
      check("rst_m_rd_flg", bus.m_rd_flg, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_res_last", bus.res_last, 0);
      check("rst_errs", {cmd_err, start_err, timeout_err, ovf_err}, 0);
      check("rst_idle", idle, 1);
   endtask

   // Presents one descriptor for a single cycle and checks the outcome.
   task automatic send_cmd(input logic rw, input logic [6:0] adr, input logic [2:0] nb,
                           input logic [3:0] ch, input logic [31:0] wd, output bit ok);
      ok = (nb >= 3'd1) && (nb <= 3'd4) && !(rw && ch == 4'd0);
      check("cmd_ready_before", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = {rw, adr, nb, ch, 1'b0, wd};
      step();
      bus.cmd_valid = 1'b0;
      if (ok) begin
         e_adr    = adr;
         e_wd     = wd;
         e_wb     = rw ? 3'd0 : nb;
         e_rb     = rw ? nb : 3'd0;
         e_ch     = rw ? ch : 4'd0;
         rd_count = 0;
         cur_ch   = e_ch;
         check("wr_flg_pulse", bus.m_wr_flg, !rw);
         check("rd_flg_pulse", bus.m_rd_flg, rw);
         check("cmd_ready_busy", bus.cmd_ready, 0);
      end else begin
         check("cmd_err_set", cmd_err, 1);
         check("rej_flags", {bus.m_wr_flg, bus.m_rd_flg}, 0);
         check("rej_cmd_ready", bus.cmd_ready, 1);
      end
      check("m_adr", bus.m_adr, e_adr);
      check("m_wr_data", bus.m_wr_data, e_wd);
      check("m_wr_bytes", bus.m_wr_bytes, e_wb);
      check("m_rd_bytes", bus.m_rd_bytes, e_rb);
      check("m_rd_channels", bus.m_rd_channels, e_ch);
   endtask

   // Steps until cmd_ready returns (bounded) and checks the number of clocks.
   task automatic wait_ready(input string tag, input int expected);
      int k = 0;
      do begin
         step();
         k++;
      end while (!bus.cmd_ready && k < 5000);
      check(tag, k, expected);
   endtask

   // Called in the cycle after acceptance: models the master for one transaction.
   task automatic run_txn(input int arm_delay, input int busy_len, input int nstrobes,
                          input bit rand_ready);
      step();
      check("flag_one_cycle", {bus.m_wr_flg, bus.m_rd_flg}, 0);
      repeat (arm_delay) step();
      bus.m_busy = 1'b1;
      for (int i = 0; i < busy_len; i++) begin
         bus.m_rd_data_en = (i < nstrobes);
         bus.m_rd_data    = wdata[i % 16];
         bus.res_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
         step();
      end
      bus.m_rd_data_en = 1'b0;
      bus.m_busy       = 1'b0;
      bus.res_ready    = 1'b0;
      wait_ready("gap_to_ready", GAP + 1);
      check("no_start_err", start_err, 0);
   endtask

   task automatic drain();
      bus.res_ready = 1'b1;
      for (int k = 0; k < 40 && q.size() != 0; k++) step();
      bus.res_ready = 1'b0;
      step();
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      check("errs_cleared", {cmd_err, start_err, timeout_err, ovf_err}, 0);
   endtask

   initial begin
      bit ok;
      logic rw;
      logic [2:0] nb;
      logic [3:0] ch;
      void'($urandom(32'd20240611));

      reset            = 1'b1;
      clear_err        = 1'b0;
      bus.cmd_valid    = 1'b0;
      bus.cmd_data     = '0;
      bus.m_rd_data    = '0;
      bus.m_rd_data_en = 1'b0;
      bus.m_busy       = 1'b0;
      bus.res_ready    = 1'b0;
      rd_count = 0; cur_ch = 0; exp_ovf = 1'b0;
      e_adr = '0; e_wd = '0; e_wb = '0; e_rb = '0; e_ch = '0;
      for (int i = 0; i < 16; i++) wdata[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      reset = 1'b0;
      step();
      check("ready_after_reset", bus.cmd_ready, 1);

      // Write with a long busy period; ready returns GAP+1 clocks after busy falls.
      send_cmd(1'b0, 7'h48, 3'd2, 4'd0, 32'hA55A0000, ok);
      run_txn(0, 2000, 0, 1'b0);

      // Read of three channels; words come back in order, last on the third.
      wdata[0] = 32'h12340000;
      wdata[1] = 32'h56780000;
      wdata[2] = 32'h9ABC0000;
      send_cmd(1'b1, 7'h40, 3'd2, 4'd3, 32'h0, ok);
      run_txn(1, 6, 3, 1'b0);
      check("read_words_held", q.size(), 3);
      drain();
      check("idle_after_read", idle, 1);

      // Rejections: nbytes 5, nbytes 0, read with zero channels (with a
      // simultaneous clear, where the new error must win).
      send_cmd(1'b0, 7'h11, 3'd5, 4'd2, 32'hDEADBEEF, ok);
      send_cmd(1'b1, 7'h12, 3'd0, 4'd2, 32'h0, ok);
      clear_err = 1'b1;
      send_cmd(1'b1, 7'h13, 3'd2, 4'd0, 32'h0, ok);
      clear_err = 1'b0;
      pulse_clear();

      // Master never raises busy: start_err after ARM clocks, then a full gap.
      send_cmd(1'b0, 7'h22, 3'd4, 4'd0, 32'h01020304, ok);
      step();
      repeat (ARM - 1) step();
      check("start_err_not_yet", start_err, 0);
      check("still_arming", bus.cmd_ready, 0);
      step();
      check("start_err_set", start_err, 1);
      wait_ready("start_gap", GAP);
      pulse_clear();

      // Busy stuck high past the timeout: flag set, block keeps waiting.
      send_cmd(1'b0, 7'h23, 3'd1, 4'd0, 32'h000000FF, ok);
      step();
      bus.m_busy = 1'b1;
      repeat (int'(TMO) - 10) step();
      check("timeout_not_yet", timeout_err, 0);
      repeat (20) step();
      check("timeout_set", timeout_err, 1);
      check("timeout_in_run", bus.cmd_ready, 0);
      repeat (50) step();
      check("timeout_still_run", bus.cmd_ready, 0);
      bus.m_busy = 1'b0;
      wait_ready("timeout_gap", GAP + 1);
      pulse_clear();

      // Overflow: nine pushes with no pop keep eight and set ovf_err.
      for (int i = 0; i < 9; i++) begin
         bus.m_rd_data_en = 1'b1;
         bus.m_rd_data    = $urandom;
         step();
      end
      bus.m_rd_data_en = 1'b0;
      check("ovf_set", ovf_err, 1);
      check("ovf_held_words", q.size(), DEPTH);
      pulse_clear();
      // Full FIFO with a same-cycle pop accepts the push.
      bus.m_rd_data_en = 1'b1;
      bus.m_rd_data    = 32'hCAFEF00D;
      bus.res_ready    = 1'b1;
      step();
      bus.m_rd_data_en = 1'b0;
      bus.res_ready    = 1'b0;
      check("full_pop_no_ovf", ovf_err, 0);
      drain();

      // Randomized descriptors and master behaviour.
      for (int t = 0; t < 14; t++) begin
         rw = 1'($urandom_range(0, 1));
         nb = 3'($urandom_range(0, 5));
         ch = 4'($urandom_range(0, 6));
         for (int i = 0; i < 16; i++) wdata[i] = $urandom;
         send_cmd(rw, 7'($urandom), nb, ch, $urandom, ok);
         if (ok) begin
            run_txn($urandom_range(0, ARM - 1), int'(ch) + $urandom_range(1, 10),
                    rw ? int'(ch) : 0, 1'b1);
            drain();
         end else begin
            pulse_clear();
         end
      end

      // Reset during RUN with words buffered.
      send_cmd(1'b1, 7'h33, 3'd3, 4'd4, 32'h0, ok);
      step();
      bus.m_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.m_rd_data_en = (i < 2);
         bus.m_rd_data    = $urandom;
         step();
      end
      bus.m_rd_data_en = 1'b0;
      check("run_has_words", bus.res_valid, 1);
      reset = 1'b1;
      #1;
      bus.m_busy = 1'b0;
      q.delete();
      exp_ovf = 1'b0; rd_count = 0; cur_ch = 0;
      e_adr = '0; e_wd = '0; e_wb = '0; e_rb = '0; e_ch = '0;
      check_reset_values();
      step();
      reset = 1'b0;
      step();
      check("ready_after_midreset", bus.cmd_ready, 1);
      check("idle_after_midreset", idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
